// File: rtl/uart_pkg.sv
// ============================================================================
// uart_pkg : state encoding and default bit timing shared by the UART blocks
// Rev 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } uart_state_e;

    localparam int DEFAULT_CLKS_PER_BIT = 434;

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// sync_2ff : two-flop synchroniser for an asynchronous input, reset to 1
// Rev 1.0
// ============================================================================
`default_nettype none

module sync_2ff (
    input  logic clk_fast,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_fast) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
// uart_rx : 8N1 serial receiver timed by an internal per-bit counter
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk_fast,
    input  logic                 rst,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int c_CNT_W = $clog2(CLKS_PER_BIT);
    localparam int c_IDX_W = $clog2(DATA_BITS + 1);
    localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_CNT_W-1:0] c_BIT_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST  = c_IDX_W'(DATA_BITS - 1);

    logic                 rx_s;
    uart_state_e          state_q;
    logic [c_CNT_W-1:0]   cnt_q, cnt_d;
    logic [c_IDX_W-1:0]   bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q;
    logic                 frame_err_q;
    logic                 w_half_hit;
    logic                 w_bit_hit;
    logic                 w_state_change;

    sync_2ff u_sync (
        .clk_fast (clk_fast),
        .rst      (rst),
        .d        (rx_in),
        .q        (rx_s)
    );

    assign w_half_hit = (state_q == S_START) && (cnt_q == c_HALF_LAST);
    assign w_bit_hit  = (cnt_q == c_BIT_LAST);

    always_comb begin
        w_state_change = 1'b0;
        case (state_q)
            S_IDLE:  w_state_change = !rx_s;
            S_START: w_state_change = w_half_hit;
            S_DATA:  w_state_change = w_bit_hit && (bit_idx_q == c_IDX_LAST);
            S_STOP:  w_state_change = w_bit_hit;
            default: w_state_change = 1'b1;
        endcase
    end

    // Counter wraps at every data sample so each bit is timed from the previous mid-point.
    always_comb begin
        cnt_d     = cnt_q + 1'b1;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        if ((state_q == S_IDLE) || w_state_change || ((state_q == S_DATA) && w_bit_hit)) begin
            cnt_d = '0;
        end
        if (state_q == S_START) begin
            bit_idx_d = '0;
        end
        if ((state_q == S_DATA) && w_bit_hit) begin
            shift_d   = (shift_q >> 1) | (DATA_BITS'(rx_s) << (DATA_BITS - 1));
            bit_idx_d = bit_idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk_fast) begin
        if (rst) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
        end
    end

    always_ff @(posedge clk_fast) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (!rx_s) state_q <= S_START;
                end
                S_START: begin
                    if (w_half_hit) state_q <= rx_s ? S_IDLE : S_DATA;
                end
                S_DATA: begin
                    if (w_bit_hit && (bit_idx_q == c_IDX_LAST)) state_q <= S_STOP;
                end
                S_STOP: begin
                    // Leave at mid stop bit so the next start edge is not missed.
                    if (w_bit_hit) begin
                        state_q <= S_IDLE;
                        if (rx_s) begin
                            rx_data_q  <= shift_q;
                            rx_valid_q <= 1'b1;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != S_IDLE);

endmodule

`default_nettype wire
